// File: rtl/sop_truth_eval_pkg.sv
// Shared definitions for the programmable sum-of-products evaluator.
package sop_truth_eval_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SWEEP = 2'd1,
    S_DONE  = 2'd2
  } state_t;

endpackage

// File: rtl/sop_truth_eval_table.sv
// Truth-table storage: 2^N_IN rows of N_CH bits, one synchronous write port and one asynchronous read port.
module sop_truth_table #(
  parameter int N_IN = 4,
  parameter int N_CH = 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            we,
  input  logic [N_IN-1:0] waddr,
  input  logic [N_CH-1:0] wdata,
  input  logic [N_IN-1:0] raddr,
  output logic [N_CH-1:0] rdata
);

  localparam int ROWS = 1 << N_IN;

  logic [N_CH-1:0] mem_q [ROWS];
  logic [N_CH-1:0] mem_d [ROWS];

  always_comb begin
    mem_d = mem_q;
    if (we) mem_d[waddr] = wdata;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) mem_q <= '{default: '0};
    else     mem_q <= mem_d;
  end

  assign rdata = mem_q[raddr];

endmodule

// File: rtl/sop_truth_eval.sv
// N-input sum-of-products evaluator: direct registered evaluation in IDLE, or an automatic sweep
// over every input row that streams each row with its outputs and counts true minterms per channel.
module sop_truth_eval
  import sop_truth_eval_pkg::*;
#(
  parameter int N_IN = 4,
  parameter int N_CH = 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     cfg_we,
  input  logic [N_IN-1:0]          cfg_addr,
  input  logic [N_CH-1:0]          cfg_data,
  input  logic [N_IN-1:0]          in_vec,
  input  logic                     start,
  output logic [N_CH-1:0]          out_q,
  output logic [N_IN-1:0]          row_vec,
  output logic                     row_valid,
  output logic                     busy,
  output logic                     done,
  output logic [N_CH*(N_IN+1)-1:0] ones_cnt
);

  localparam int CNT_W = N_IN + 1;
  localparam logic [N_IN-1:0] LAST_ROW = '1;

  state_t                      state_q, state_d;
  logic [N_IN-1:0]             row_q, row_d;
  logic [N_IN-1:0]             row_vec_q, row_vec_d;
  logic [N_CH-1:0]             out_d;
  logic [N_CH-1:0][CNT_W-1:0]  cnt_q, cnt_d;
  logic [N_IN-1:0]             next_row;
  logic [N_IN-1:0]             rd_addr;
  logic [N_CH-1:0]             rd_data;
  logic [N_CH-1:0]             first_data;
  logic                        idle;
  logic                        accept;
  logic                        tbl_we;

  assign idle     = (state_q == S_IDLE);
  assign accept   = idle && start;
  assign tbl_we   = idle && cfg_we;
  assign next_row = row_q + N_IN'(1);

  // Outputs are fetched one row ahead so that row 0 is already on out_q in the first sweep cycle.
  always_comb begin
    rd_addr = next_row;
    if (idle) rd_addr = start ? '0 : in_vec;
  end

  // A row-0 write landing on the accept edge is not yet in the table, so forward it.
  always_comb begin
    first_data = rd_data;
    if (accept && cfg_we && (cfg_addr == '0)) first_data = cfg_data;
  end

  sop_truth_table #(
    .N_IN (N_IN),
    .N_CH (N_CH)
  ) u_table (
    .clk   (clk),
    .rst   (rst),
    .we    (tbl_we),
    .waddr (cfg_addr),
    .wdata (cfg_data),
    .raddr (rd_addr),
    .rdata (rd_data)
  );

  always_comb begin
    state_d   = state_q;
    row_d     = row_q;
    row_vec_d = row_vec_q;
    out_d     = out_q;
    cnt_d     = cnt_q;
    unique case (state_q)
      S_IDLE: begin
        out_d     = first_data;
        row_vec_d = rd_addr;
        if (start) begin
          state_d = S_SWEEP;
          row_d   = '0;
          cnt_d   = '0;
        end
      end
      S_SWEEP: begin
        for (int unsigned c = 0; c < N_CH; c++) begin
          cnt_d[c] = cnt_q[c] + CNT_W'(out_q[c]);
        end
        row_d = next_row;
        if (row_q == LAST_ROW) begin
          state_d = S_DONE;
        end else begin
          out_d     = rd_data;
          row_vec_d = next_row;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      row_q     <= '0;
      row_vec_q <= '0;
      out_q     <= '0;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      row_q     <= row_d;
      row_vec_q <= row_vec_d;
      out_q     <= out_d;
      cnt_q     <= cnt_d;
    end
  end

  assign row_vec   = row_vec_q;
  assign row_valid = (state_q == S_SWEEP);
  assign busy      = (state_q != S_IDLE);
  assign done      = (state_q == S_DONE);
  assign ones_cnt  = cnt_q;

endmodule

// File: tb/tb_sop_truth_eval.sv
// Scoreboard bench for sop_truth_eval: a 4-input single-channel instance and a 2-input dual-channel instance.
module tb_sop_truth_eval;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst, cfg_we, start;
  logic [3:0] cfg_addr, in_vec, row_vec;
  logic [0:0] cfg_data, out_q;
  logic       row_valid, busy, done;
  logic [4:0] ones_cnt;

  logic       cfg_we2, start2;
  logic [1:0] cfg_addr2, in_vec2, row_vec2, cfg_data2, out_q2;
  logic       row_valid2, busy2, done2;
  logic [5:0] ones_cnt2;

  sop_truth_eval #(.N_IN(4), .N_CH(1)) dut (
    .clk(clk), .rst(rst), .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_data(cfg_data),
    .in_vec(in_vec), .start(start), .out_q(out_q), .row_vec(row_vec), .row_valid(row_valid),
    .busy(busy), .done(done), .ones_cnt(ones_cnt)
  );

  sop_truth_eval #(.N_IN(2), .N_CH(2)) dut2 (
    .clk(clk), .rst(rst), .cfg_we(cfg_we2), .cfg_addr(cfg_addr2), .cfg_data(cfg_data2),
    .in_vec(in_vec2), .start(start2), .out_q(out_q2), .row_vec(row_vec2), .row_valid(row_valid2),
    .busy(busy2), .done(done2), .ones_cnt(ones_cnt2)
  );

  typedef struct packed {
    logic [3:0] row;
    logic [1:0] val;
  } exp_t;

  exp_t        sb[$];
  logic [15:0] model;
  int          errors = 0;
  int          checks = 0;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    checks++;
    if ({out_q, row_vec, row_valid, busy, done, ones_cnt} !== 12'h000) begin
      errors++;
      $display("FAIL reset_held: got out=%b row=%h valid=%b busy=%b done=%b cnt=%0d, want all 0",
               out_q, row_vec, row_valid, busy, done, ones_cnt);
    end
    rst = 1'b0;
    tick();
    checks++;
    if ({out_q, row_vec, row_valid, busy, done, ones_cnt} !== 12'h000) begin
      errors++;
      $display("FAIL reset_release: got out=%b row=%h valid=%b busy=%b done=%b cnt=%0d, want all 0",
               out_q, row_vec, row_valid, busy, done, ones_cnt);
    end
  endtask

  task automatic test_direct(input string name);
    logic [3:0] pats [5];
    exp_t e;
    pats = '{4'h0, 4'h5, 4'h6, 4'hC, 4'h3};
    for (int i = 0; i < 5; i++) begin
      in_vec = pats[i];
      e.row = pats[i];
      e.val = {1'b0, model[pats[i]]};
      sb.push_back(e);
      tick();
      e = sb.pop_front();
      checks++;
      if ({busy, row_valid, row_vec, out_q} !== {1'b0, 1'b0, e.row, e.val[0]}) begin
        errors++;
        $display("FAIL %s in_vec=%h: got busy=%b valid=%b row=%h out=%b, want busy=0 valid=0 row=%h out=%b",
                 name, pats[i], busy, row_valid, row_vec, out_q, e.row, e.val[0]);
      end
    end
  endtask

  task automatic test_write();
    logic [3:0] rows [4];
    rows = '{4'h0, 4'h5, 4'h6, 4'hC};
    for (int i = 0; i < 4; i++) begin
      cfg_we = 1'b1;
      cfg_addr = rows[i];
      cfg_data = 1'b1;
      model[rows[i]] = 1'b1;
      tick();
    end
    cfg_we = 1'b0;
    test_direct("direct_programmed");
  endtask

  task automatic run_sweep(input string name, input bit pre_we, input logic [3:0] pre_addr,
                           input bit mid_we, input logic [3:0] mid_addr);
    exp_t e;
    int   exp_ones;
    if (pre_we) begin
      cfg_we = 1'b1;
      cfg_addr = pre_addr;
      cfg_data = 1'b1;
      model[pre_addr] = 1'b1;
    end
    exp_ones = 0;
    for (int r = 0; r < 16; r++) begin
      e.row = 4'(r);
      e.val = {1'b0, model[r]};
      sb.push_back(e);
      exp_ones += int'(model[r]);
    end
    start = 1'b1;
    in_vec = 4'hA;
    tick();
    start = 1'b0;
    cfg_we = 1'b0;
    for (int k = 1; k <= 16; k++) begin
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL %s scoreboard empty at cycle %0d", name, k);
      end else begin
        e = sb.pop_front();
        checks++;
        if ({row_valid, busy, done, row_vec, out_q} !== {1'b1, 1'b1, 1'b0, e.row, e.val[0]}) begin
          errors++;
          $display("FAIL %s cycle %0d: got valid=%b busy=%b done=%b row=%h out=%b, want 1 1 0 row=%h out=%b",
                   name, k, row_valid, busy, done, row_vec, out_q, e.row, e.val[0]);
        end
      end
      cfg_we   = mid_we && (k == 9);
      start    = mid_we && (k == 9);
      cfg_addr = mid_addr;
      cfg_data = 1'b1;
      tick();
    end
    cfg_we = 1'b0;
    start = 1'b0;
    checks++;
    if ({done, row_valid, busy, ones_cnt} !== {1'b1, 1'b0, 1'b1, 5'(exp_ones)}) begin
      errors++;
      $display("FAIL %s done_cycle: got done=%b valid=%b busy=%b cnt=%0d, want 1 0 1 cnt=%0d",
               name, done, row_valid, busy, ones_cnt, exp_ones);
    end
    tick();
    checks++;
    if ({done, row_valid, busy, ones_cnt} !== {1'b0, 1'b0, 1'b0, 5'(exp_ones)}) begin
      errors++;
      $display("FAIL %s back_to_idle: got done=%b valid=%b busy=%b cnt=%0d, want 0 0 0 cnt=%0d",
               name, done, row_valid, busy, ones_cnt, exp_ones);
    end
    in_vec = 4'h0;
  endtask

  task automatic test_reset_mid_sweep();
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int k = 1; k < 8; k++) tick();
    checks++;
    if ({row_valid, row_vec} !== {1'b1, 4'h7}) begin
      errors++;
      $display("FAIL rst_mid_position: got valid=%b row=%h, want valid=1 row=7", row_valid, row_vec);
    end
    rst = 1'b1;
    #1;
    checks++;
    if ({out_q, row_vec, row_valid, busy, done, ones_cnt} !== 12'h000) begin
      errors++;
      $display("FAIL rst_mid_async: got out=%b row=%h valid=%b busy=%b done=%b cnt=%0d, want all 0",
               out_q, row_vec, row_valid, busy, done, ones_cnt);
    end
    for (int k = 0; k < 3; k++) begin
      tick();
      checks++;
      if ({done, busy} !== 2'b00) begin
        errors++;
        $display("FAIL rst_mid_no_done: got done=%b busy=%b, want 0 0", done, busy);
      end
    end
    rst = 1'b0;
    tick();
    model = '0;
    run_sweep("sweep_after_reset", 1'b0, 4'h0, 1'b0, 4'h0);
  endtask

  task automatic test_two_channel();
    logic [1:0] tbl2 [4];
    exp_t       e;
    int         c0, c1;
    c0 = 0;
    c1 = 0;
    for (int r = 0; r < 4; r++) begin
      tbl2[r] = {r[1] ^ r[0], r[1] & r[0]};
      c0 += int'(tbl2[r][0]);
      c1 += int'(tbl2[r][1]);
      cfg_we2 = 1'b1;
      cfg_addr2 = 2'(r);
      cfg_data2 = tbl2[r];
      tick();
    end
    cfg_we2 = 1'b0;
    for (int r = 0; r < 4; r++) begin
      e.row = 4'(r);
      e.val = tbl2[r];
      sb.push_back(e);
    end
    start2 = 1'b1;
    tick();
    start2 = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      e = sb.pop_front();
      checks++;
      if ({row_valid2, done2, row_vec2, out_q2} !== {1'b1, 1'b0, e.row[1:0], e.val}) begin
        errors++;
        $display("FAIL two_ch cycle %0d: got valid=%b done=%b row=%h out=%b, want 1 0 row=%h out=%b",
                 k, row_valid2, done2, row_vec2, out_q2, e.row[1:0], e.val);
      end
      tick();
    end
    checks++;
    if ({done2, row_valid2, ones_cnt2} !== {1'b1, 1'b0, 3'(c1), 3'(c0)}) begin
      errors++;
      $display("FAIL two_ch_done: got done=%b valid=%b cnt=%h, want done=1 valid=0 cnt=%h",
               done2, row_valid2, ones_cnt2, {3'(c1), 3'(c0)});
    end
    tick();
    checks++;
    if ({busy2, done2} !== 2'b00) begin
      errors++;
      $display("FAIL two_ch_idle: got busy=%b done=%b, want 0 0", busy2, done2);
    end
  endtask

  initial begin
    rst = 1'b1; cfg_we = 1'b0; cfg_addr = '0; cfg_data = '0; in_vec = '0; start = 1'b0;
    cfg_we2 = 1'b0; cfg_addr2 = '0; cfg_data2 = '0; in_vec2 = '0; start2 = 1'b0;
    model = '0;
    test_reset();
    test_direct("direct_empty");
    test_write();
    run_sweep("sweep_basic", 1'b0, 4'h0, 1'b0, 4'h0);
    run_sweep("sweep_start_with_write", 1'b1, 4'hF, 1'b1, 4'h3);
    run_sweep("sweep_ignored_write", 1'b0, 4'h0, 1'b0, 4'h0);
    test_reset_mid_sweep();
    test_two_channel();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
